// File: rtl/conv_binario_bcd_pkg.sv
// ---------------------------------------------------------------------------
// conv_binario_bcd_pkg
// Shared definitions for the binary <-> BCD converters: operand and BCD
// widths, iteration count, largest valid value, default error code and the
// converter FSM state encoding. Also holds a small range-check helper.
// ---------------------------------------------------------------------------
package conv_binario_bcd_pkg;

   // Binary operand width (0..127 representable, 0..99 valid)
   localparam int OP_W   = 7;
   // Packed two-digit BCD width: tens in [7:4], units in [3:0]
   localparam int BCD_W  = 8;
   // Width of one BCD digit
   localparam int NIB_W  = 4;
   // Double-dabble steps per conversion (one per operand bit)
   localparam int N_ITER = 7;
   // Iteration counter width
   localparam int CNT_W  = 3;

   // Largest operand that still fits in two BCD digits
   localparam logic [OP_W-1:0]  MAX_VAL      = 7'd99;
   // Default BCD word reported for out-of-range operands
   localparam logic [BCD_W-1:0] ERR_CODE_DEF = 8'hFF;
   // Counter value during the final double-dabble step
   localparam logic [CNT_W-1:0] LAST_STEP    = CNT_W'(N_ITER - 1);

   // Converter FSM states
   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } estado_t;

   // True when the operand cannot be represented in two BCD digits
   function automatic logic fuera_de_rango(input logic [OP_W-1:0] i_valor);
      return (i_valor > MAX_VAL);
   endfunction

endpackage : conv_binario_bcd_pkg

// File: rtl/ajuste_nibble_bcd.sv
// ---------------------------------------------------------------------------
// ajuste_nibble_bcd
// Combinational double-dabble correction for one BCD digit: adds 3 when the
// digit is 5 or more so that the following left shift carries correctly into
// the next digit. 4-bit arithmetic, no carry out.
//
// Ports
//   i_nib : digit before correction
//   o_nib : digit after correction
// ---------------------------------------------------------------------------
module ajuste_nibble_bcd
   import conv_binario_bcd_pkg::*;
(
   input  logic [NIB_W-1:0] i_nib,
   output logic [NIB_W-1:0] o_nib
);

   // Add-3 correction for digits >= 5
   always_comb begin
      o_nib = i_nib;
      if (i_nib >= 4'd5) begin
         o_nib = i_nib + 4'd3;
      end else begin
         o_nib = i_nib;
      end
   end

endmodule : ajuste_nibble_bcd

// File: rtl/conv_binario_bcd.sv
// ---------------------------------------------------------------------------
// conv_binario_bcd
// Sequential 7-bit binary to 2-digit BCD converter (double dabble).
// A start in IDLE latches the operand; seven shift/correct steps follow in
// CONV, after which the result is registered and done pulses for one cycle.
// Operands above 99 produce ERR_CODE with error set.
//
// Parameters
//   ERR_CODE : BCD word reported for out-of-range operands
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, sampled only in IDLE
//   dato_bin : binary operand, valid range 0..99
//   dato_bcd : registered result, tens [7:4], units [3:0]
//   busy     : high while a conversion is in progress
//   done     : one-cycle pulse when a new dato_bcd is valid
//   error    : registered with dato_bcd, high when operand was > 99
// ---------------------------------------------------------------------------
module conv_binario_bcd
   import conv_binario_bcd_pkg::*;
#(
   parameter logic [BCD_W-1:0] ERR_CODE = ERR_CODE_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  dato_bin,
   output logic [BCD_W-1:0] dato_bcd,
   output logic             busy,
   output logic             done,
   output logic             error
);

   // State and datapath registers
   estado_t            r_state;
   logic [OP_W-1:0]    r_op;
   logic [BCD_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_range;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_error;
   logic               r_busy;
   logic               r_done;

   // Next-state values
   estado_t            w_state_nxt;
   logic [OP_W-1:0]    w_op_nxt;
   logic [BCD_W-1:0]   w_acc_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_range_nxt;
   logic [BCD_W-1:0]   w_bcd_nxt;
   logic               w_error_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   // Datapath
   logic [NIB_W-1:0]   w_decenas_adj;
   logic [NIB_W-1:0]   w_unidades_adj;
   logic [BCD_W-1:0]   w_acc_adj;
   logic [BCD_W-1:0]   w_acc_shift;
   logic [OP_W-1:0]    w_op_shift;
   logic               w_ovf;

   ajuste_nibble_bcd u_ajuste_decenas (
      .i_nib (r_acc[7:4]),
      .o_nib (w_decenas_adj)
   );

   ajuste_nibble_bcd u_ajuste_unidades (
      .i_nib (r_acc[3:0]),
      .o_nib (w_unidades_adj)
   );

   assign w_acc_adj = {w_decenas_adj, w_unidades_adj};

   // One double-dabble step: correct, then shift {acc, op} left by one with
   // the operand MSB entering the accumulator LSB.
   assign w_acc_shift = {w_acc_adj[6:0], r_op[OP_W-1]};
   assign w_op_shift  = {r_op[OP_W-2:0], 1'b0};
   // Bit shifted out of the tens digit; only reachable for operands > 99,
   // folded into the range flag so it is never silently dropped.
   assign w_ovf       = w_acc_adj[7];

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_range_nxt = r_range;
      w_bcd_nxt   = r_bcd;
      w_error_nxt = r_error;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_op_nxt    = dato_bin;
               w_acc_nxt   = 8'h00;
               w_cnt_nxt   = 3'd0;
               w_range_nxt = fuera_de_rango(dato_bin);
               w_busy_nxt  = 1'b1;
               w_state_nxt = CONV;
            end else begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end

         CONV: begin
            w_acc_nxt   = w_acc_shift;
            w_op_nxt    = w_op_shift;
            w_range_nxt = r_range | w_ovf;
            if (r_cnt == LAST_STEP) begin
               // Final step: publish the freshly shifted accumulator
               w_bcd_nxt   = (r_range | w_ovf) ? ERR_CODE : w_acc_shift;
               w_error_nxt = r_range | w_ovf;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_cnt_nxt   = 3'd0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt   = r_cnt + 3'd1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = CONV;
            end
         end

         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_op    <= 7'd0;
         r_acc   <= 8'h00;
         r_cnt   <= 3'd0;
         r_range <= 1'b0;
         r_bcd   <= 8'h00;
         r_error <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_range <= w_range_nxt;
         r_bcd   <= w_bcd_nxt;
         r_error <= w_error_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign dato_bcd = r_bcd;
   assign error    = r_error;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule : conv_binario_bcd

// File: doc/conv_binario_bcd.md
CONV_BINARIO_BCD -- requirements
Module: conv_binario_bcd

Interface
REQ-001 The block SHALL have parameter ERR_CODE, default 8'hFF, as the BCD word output for out-of-range operands.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-004 Port start SHALL be an input, 1 bit wide: a conversion request, sampled only in IDLE.
REQ-005 Port dato_bin SHALL be an input, 7 bits wide: the unsigned binary operand, valid range 0..99.
REQ-006 Port dato_bcd SHALL be an output, 8 bits wide: the registered result, tens in [7:4] and units in [3:0].
REQ-007 Port busy SHALL be an output, 1 bit wide: high while a conversion is in progress.
REQ-008 Port done SHALL be an output, 1 bit wide: a one-cycle pulse marking when a new dato_bcd is valid.
REQ-009 Port error SHALL be an output, 1 bit wide: registered alongside dato_bcd, high when the last operand was greater than 99.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and CONV.
REQ-011 In IDLE with start=1, the block SHALL, on the next edge (E0):
- latch dato_bin into a 7-bit operand shift register;
- clear the 8-bit BCD accumulator;
- clear the 3-bit iteration counter;
- record range flag (dato_bin>99);
- go to CONV.
REQ-012 In CONV, each edge SHALL perform one double-dabble step:
- add 3 to each accumulator nibble that is >=5;
- then shift {accumulator, operand} left by 1, operand MSB entering accumulator LSB.
REQ-013 CONV SHALL execute exactly 7 steps, on edges E1..E7, independent of operand value.
REQ-014 At E7 the block SHALL:
- load dato_bcd (accumulator, or ERR_CODE if the range flag is set);
- load error from the range flag;
- set done=1 for one cycle;
- return to IDLE.
REQ-015 busy SHALL be high from E0 through the cycle before E7 and low after E7; done SHALL be high only in the cycle after E7.
REQ-016 Latency from the start-sampling edge to the done pulse SHALL be 7 clock cycles; throughput SHALL be one conversion per 8 cycles.
REQ-017 start SHALL be ignored while in CONV; there SHALL be no queuing.
REQ-018 start=1 in the done cycle SHALL be accepted as a new request (FSM is in IDLE).
REQ-019 Changes on dato_bin after E0 SHALL NOT affect the conversion in progress.
REQ-020 dato_bcd and error SHALL hold their values between done pulses.
REQ-021 Nibble correction SHALL be 4-bit with no carry out; for operands 0..99 no nibble ever exceeds 9 after a shift.

Reset
REQ-022 rst_n=0 SHALL immediately force, regardless of clk:
- state=IDLE;
- dato_bcd=8'h00, error=0, busy=0, done=0;
- counter=0, shift registers=0.
REQ-023 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after release SHALL begin a fresh conversion.

Structure
REQ-024 A shared package SHALL hold the following, reused by the BCD-to-binary side:
- operand width 7;
- BCD width 8;
- iteration count 7;
- max valid value 99;
- ERR_CODE;
- state encoding.
REQ-025 The per-nibble add-3 correction SHALL be a combinational sub-module ajuste_nibble_bcd, instantiated twice (tens, units).

Verification
REQ-026 Bench case: dato_bin=0, start pulse -> after 7 cycles done=1, dato_bcd=8'h00, error=0.
REQ-027 Bench case: dato_bin=99 -> dato_bcd=8'h99; dato_bin=59 -> 8'h59; dato_bin=10 -> 8'h10; each with busy high for exactly 7 cycles.
REQ-028 Bench case: dato_bin=100 and dato_bin=127 -> dato_bcd=8'hFF, error=1, same 7-cycle latency; a following dato_bin=23 -> 8'h23, error=0.
REQ-029 Bench case: start re-pulsed with dato_bin=45 during a conversion of 12 -> single done, dato_bcd=8'h12.
REQ-030 Bench case: start held high continuously with dato_bin=37 -> done every 8 cycles, dato_bcd=8'h37.
REQ-031 Bench case: rst_n low at E4 of a conversion of 88 -> all outputs 0 immediately, no done; after release a new start converts 88 -> 8'h88.
